// File: rtl/axi_s_reg.sv
// AXI4 slave register bank: NREG 32-bit registers with independent read/write FSMs.
// Register 0 holds a read-only ID value; all contents are exported flat on regs_o.
module axi_s_reg #(
  parameter int          IDLEN    = 4,
  parameter int          AW       = 7,
  parameter int          BURSTL   = 4,
  parameter int          BURSTSZ  = 3,
  parameter int          BURSTW   = 2,
  parameter int          DW       = 32,
  parameter int          RESPLEN  = 2,
  parameter int          IXW      = 4,
  parameter logic [31:0] ID_VALUE = 32'h6759_0001
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [IDLEN-1:0]         awid,
  input  logic [AW-1:0]            awaddr,
  input  logic [BURSTL-1:0]        awlen,
  input  logic [BURSTSZ-1:0]       awsize,
  input  logic [BURSTW-1:0]        awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DW-1:0]            wdata,
  input  logic [DW/8-1:0]          wdatainfo,
  input  logic [DW/8-1:0]          wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [IDLEN-1:0]         bid,
  output logic [RESPLEN-1:0]       bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [IDLEN-1:0]         arid,
  input  logic [AW-1:0]            araddr,
  input  logic [BURSTL-1:0]        arlen,
  input  logic [BURSTSZ-1:0]       arsize,
  input  logic [BURSTW-1:0]        arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [IDLEN-1:0]         rid,
  output logic [DW-1:0]            rdata,
  output logic [DW/8-1:0]          rdatainfo,
  output logic [RESPLEN-1:0]       rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [(2**IXW)*DW-1:0]   regs_o
);

  localparam int NREG = 2**IXW;
  localparam int NB   = DW/8;
  localparam logic [RESPLEN-1:0] OKAY   = RESPLEN'(0);
  localparam logic [RESPLEN-1:0] SLVERR = RESPLEN'(2);
  localparam logic [RESPLEN-1:0] DECERR = RESPLEN'(3);

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
  typedef enum logic       {RIDLE, RDATA}        rstate_t;

  function automatic logic [RESPLEN-1:0] decodeErr(input logic [AW-1:0]      a,
                                                   input logic [BURSTSZ-1:0] sz,
                                                   input logic [BURSTW-1:0]  bt);
    if ((a >> (IXW+2)) != '0) return DECERR;
    if (sz != BURSTSZ'(2) || bt == BURSTW'(2) || bt == BURSTW'(3)) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [NB-1:0] byteParity(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  logic [DW-1:0] r_regs [NREG];

  // ---------------- write channel ----------------
  wstate_t              r_wstate, w_wnext;
  logic                 r_awready, r_wready, r_bvalid;
  logic [IDLEN-1:0]     r_wid, r_bid;
  logic [IXW-1:0]       r_widx;
  logic [BURSTL-1:0]    r_wlen, r_wbeat;
  logic                 r_wfixed;
  logic [RESPLEN-1:0]   r_werr, r_bresp;

  logic                 w_awHs, w_wHs, w_bHs, w_wlastBeat, w_parErr, w_wDoWrite;
  logic [RESPLEN-1:0]   w_werrNext;

  assign w_awHs      = r_awready & awvalid;
  assign w_wHs       = r_wready & wvalid;
  assign w_bHs       = r_bvalid & bready;
  assign w_wlastBeat = (r_wbeat == r_wlen);
  assign w_parErr    = |((byteParity(wdata) ^ wdatainfo) & wstrb);
  assign w_wDoWrite  = w_wHs && (r_werr == OKAY) && !w_parErr && (r_widx != '0);
  // DECERR is sticky; any bad beat (parity or wlast position) demotes OKAY to SLVERR.
  assign w_werrNext  = (r_werr == DECERR) ? DECERR :
                       (w_parErr || (wlast != w_wlastBeat)) ? SLVERR : r_werr;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      WIDLE:   if (w_awHs) w_wnext = WDATA;
      WDATA:   if (w_wHs && w_wlastBeat) w_wnext = WRESP;
      WRESP:   if (w_bHs) w_wnext = WIDLE;
      default: w_wnext = WIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wstate  <= WIDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_wid     <= '0;
      r_bid     <= '0;
      r_bresp   <= OKAY;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_wfixed  <= 1'b0;
      r_werr    <= OKAY;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == WIDLE);
      r_wready  <= (w_wnext == WDATA);
      r_bvalid  <= (w_wnext == WRESP);
      if (w_awHs) begin
        r_wid    <= awid;
        r_widx   <= awaddr[IXW+1:2];
        r_wlen   <= awlen;
        r_wbeat  <= '0;
        r_wfixed <= (awburst == BURSTW'(0));
        r_werr   <= decodeErr(awaddr, awsize, awburst);
      end
      if (w_wHs) begin
        r_werr  <= w_werrNext;
        r_wbeat <= r_wbeat + BURSTL'(1);
        if (!r_wfixed) r_widx <= r_widx + IXW'(1);
        if (w_wlastBeat) begin
          r_bid   <= r_wid;
          r_bresp <= w_werrNext;
        end
      end
    end
  end

  // Register 0 is only ever loaded by reset, which keeps it read-only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= (k == 0) ? ID_VALUE : '0;
    end else if (w_wDoWrite) begin
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) r_regs[r_widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_t              r_rstate, w_rnext;
  logic                 r_arready, r_rvalid, r_rlast, r_rfixed;
  logic [IDLEN-1:0]     r_rid;
  logic [DW-1:0]        r_rdata;
  logic [NB-1:0]        r_rdatainfo;
  logic [RESPLEN-1:0]   r_rresp, r_rerr;
  logic [IXW-1:0]       r_ridx;
  logic [BURSTL-1:0]    r_rlen, r_rbeat;

  logic                 w_arHs, w_rHs;
  logic [IXW-1:0]       w_arIdx;
  logic [RESPLEN-1:0]   w_arErr;
  logic [DW-1:0]        w_rloadData;

  assign w_arHs  = r_arready & arvalid;
  assign w_rHs   = r_rvalid & rready;
  assign w_arIdx = araddr[IXW+1:2];
  assign w_arErr = decodeErr(araddr, arsize, arburst);

  // r_ridx always points at the register the next beat will read.
  always_comb begin
    w_rloadData = '0;
    if (w_arHs) begin
      if (w_arErr == OKAY) w_rloadData = r_regs[w_arIdx];
    end else if (r_rerr == OKAY) begin
      w_rloadData = r_regs[r_ridx];
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      RIDLE:   if (w_arHs) w_rnext = RDATA;
      RDATA:   if (w_rHs && r_rlast) w_rnext = RIDLE;
      default: w_rnext = RIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rstate    <= RIDLE;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rfixed    <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= '0;
      r_rdatainfo <= '0;
      r_rresp     <= OKAY;
      r_rerr      <= OKAY;
      r_ridx      <= '0;
      r_rlen      <= '0;
      r_rbeat     <= '0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == RIDLE);
      r_rvalid  <= (w_rnext == RDATA);
      if (w_arHs) begin
        r_rid       <= arid;
        r_rlen      <= arlen;
        r_rbeat     <= '0;
        r_rfixed    <= (arburst == BURSTW'(0));
        r_rerr      <= w_arErr;
        r_ridx      <= (arburst == BURSTW'(0)) ? w_arIdx : w_arIdx + IXW'(1);
        r_rdata     <= w_rloadData;
        r_rdatainfo <= byteParity(w_rloadData);
        r_rresp     <= w_arErr;
        r_rlast     <= (arlen == '0);
      end else if (w_rHs && !r_rlast) begin
        r_rbeat     <= r_rbeat + BURSTL'(1);
        r_rdata     <= w_rloadData;
        r_rdatainfo <= byteParity(w_rloadData);
        r_rlast     <= ((r_rbeat + BURSTL'(1)) == r_rlen);
        if (!r_rfixed) r_ridx <= r_ridx + IXW'(1);
      end
    end
  end

  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign bresp     = r_bresp;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rid       = r_rid;
  assign rdata     = r_rdata;
  assign rdatainfo = r_rdatainfo;
  assign rresp     = r_rresp;
  assign rlast     = r_rlast;

  for (genvar k = 0; k < NREG; k++) begin : g_regs
    assign regs_o[DW*k +: DW] = r_regs[k];
  end

endmodule

// File: tb/tb_axi_s_reg.sv
// Directed self-checking bench for axi_s_reg: writes, bursts, error decode,
// strobes, parity, backpressure and mid-burst reset, with hand-computed expectations.
module tb_axi_s_reg;

  localparam logic [31:0] ID_VALUE = 32'h6759_0001;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  awid;
  logic [6:0]  awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wdatainfo, wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [6:0]  araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [3:0]  rdatainfo;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [16*32-1:0] regs_o;

  axi_s_reg dut (
    .clk(clk), .rstn(rstn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wdatainfo(wdatainfo), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rdatainfo(rdatainfo), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] wData [4];
  logic [31:0] rData [16];
  logic        rLast [16];
  logic [1:0]  rResp [16];
  logic [3:0]  rId   [16];
  logic [3:0]  rInfo [16];
  logic [1:0]  bRespGot;
  logic [3:0]  bIdGot;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] parity4(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [31:0] regVal(input int k);
    return regs_o[32*k +: 32];
  endfunction

  task automatic applyStimulus();
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wdatainfo = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
  endtask

  task automatic axiWrite(input logic [3:0] id, input logic [6:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int badBeat, input int bStall);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checkOutput("aw_handshake", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata     = wData[b];
      wstrb     = strb;
      wdatainfo = parity4(wData[b]) ^ ((b == badBeat) ? 4'b0001 : 4'b0000);
      wlast     = (b == int'(len));
      wvalid    = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) checkOutput("w_handshake", {63'd0, wready}, 64'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    checkOutput("b_valid", {63'd0, bvalid}, 64'd1);
    bIdGot = bid; bRespGot = bresp;
    repeat (bStall) begin
      @(negedge clk);
      checkOutput("b_hold", {57'd0, bvalid, bid, bresp}, {57'd0, 1'b1, bIdGot, bRespGot});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checkOutput("b_drop", {63'd0, bvalid}, 64'd0);
  endtask

  task automatic axiRead(input logic [3:0] id, input logic [6:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stallMode);
    int n;
    logic [42:0] hold;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    checkOutput("ar_handshake", {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("r_latency", {63'd0, rvalid}, 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) checkOutput("r_valid", {63'd0, rvalid}, 64'd1);
      if (stallMode != 0 && $urandom_range(0, 1) == 1) begin
        hold   = {rid, rresp, rlast, rdatainfo, rdata};
        rready = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          checkOutput("r_hold", {20'd0, rvalid, rid, rresp, rlast, rdatainfo, rdata}, {20'd0, 1'b1, hold});
        end
      end
      rData[b] = rdata; rLast[b] = rlast; rResp[b] = rresp; rId[b] = rid; rInfo[b] = rdatainfo;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    checkOutput("r_done", {63'd0, rvalid}, 64'd0);
  endtask

  logic [31:0] expBurst [4];
  int          n0;

  initial begin
    applyStimulus();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", {63'd0, awready}, 64'd0);
    checkOutput("rst_arready", {63'd0, arready}, 64'd0);
    checkOutput("rst_bvalid",  {63'd0, bvalid},  64'd0);
    checkOutput("rst_rvalid",  {63'd0, rvalid},  64'd0);
    checkOutput("rst_reg0",    {32'd0, regVal(0)}, {32'd0, ID_VALUE});
    checkOutput("rst_reg1",    {32'd0, regVal(1)}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rel_awready", {63'd0, awready}, 64'd1);
    checkOutput("rel_arready", {63'd0, arready}, 64'd1);

    // Single write with B backpressure, then single read back
    wData[0] = 32'hDEAD_BEEF;
    axiWrite(4'd5, 7'h04, 4'd0, 3'd2, 2'b01, 4'hF, -1, 5);
    checkOutput("t1_bresp", {62'd0, bRespGot}, 64'd0);
    checkOutput("t1_bid",   {60'd0, bIdGot},   64'd5);
    checkOutput("t1_reg1",  {32'd0, regVal(1)}, {32'd0, 32'hDEAD_BEEF});
    axiRead(4'd9, 7'h04, 4'd0, 3'd2, 2'b01, 0);
    checkOutput("t1_rdata", {32'd0, rData[0]}, {32'd0, 32'hDEAD_BEEF});
    checkOutput("t1_rlast", {63'd0, rLast[0]}, 64'd1);
    checkOutput("t1_rresp", {62'd0, rResp[0]}, 64'd0);
    checkOutput("t1_rid",   {60'd0, rId[0]},   64'd9);
    checkOutput("t1_rinfo", {60'd0, rInfo[0]}, 64'h5);

    // INCR burst wrapping 15 -> 0 -> 1, reg0 write ignored
    wData[0] = 32'd1; wData[1] = 32'd2; wData[2] = 32'd3;
    axiWrite(4'd6, 7'h3C, 4'd2, 3'd2, 2'b01, 4'hF, -1, 0);
    checkOutput("t2_bresp", {62'd0, bRespGot}, 64'd0);
    checkOutput("t2_reg15", {32'd0, regVal(15)}, 64'd1);
    checkOutput("t2_reg0",  {32'd0, regVal(0)},  {32'd0, ID_VALUE});
    checkOutput("t2_reg1",  {32'd0, regVal(1)},  64'd3);
    expBurst[0] = 32'd0; expBurst[1] = 32'd1; expBurst[2] = ID_VALUE; expBurst[3] = 32'd3;
    axiRead(4'd2, 7'h38, 4'd3, 3'd2, 2'b01, 1);
    for (int b = 0; b < 4; b++) begin
      checkOutput("t2_rdata", {32'd0, rData[b]}, {32'd0, expBurst[b]});
      checkOutput("t2_rlast", {63'd0, rLast[b]}, {63'd0, (b == 3)});
      checkOutput("t2_rresp", {62'd0, rResp[b]}, 64'd0);
    end

    // Error decode: DECERR on high address, SLVERR on size and WRAP
    wData[0] = 32'h1234_5678;
    axiWrite(4'd1, 7'h44, 4'd0, 3'd2, 2'b01, 4'hF, -1, 0);
    checkOutput("t3_decerr", {62'd0, bRespGot}, 64'd3);
    checkOutput("t3_reg1",   {32'd0, regVal(1)}, 64'd3);
    axiWrite(4'd1, 7'h08, 4'd0, 3'd1, 2'b01, 4'hF, -1, 0);
    checkOutput("t3_slverr", {62'd0, bRespGot}, 64'd2);
    checkOutput("t3_reg2",   {32'd0, regVal(2)}, 64'd0);
    axiRead(4'd4, 7'h04, 4'd1, 3'd2, 2'b10, 0);
    for (int b = 0; b < 2; b++) begin
      checkOutput("t3_rdata", {32'd0, rData[b]}, 64'd0);
      checkOutput("t3_rresp", {62'd0, rResp[b]}, 64'd2);
      checkOutput("t3_rlast", {63'd0, rLast[b]}, {63'd0, (b == 1)});
    end

    // Byte strobes (bytes 0 and 2) and a parity-corrupted beat
    wData[0] = 32'h1122_3344;
    axiWrite(4'd7, 7'h0C, 4'd0, 3'd2, 2'b01, 4'hF, -1, 0);
    checkOutput("t4_reg3_full", {32'd0, regVal(3)}, {32'd0, 32'h1122_3344});
    wData[0] = 32'hAABB_CCDD;
    axiWrite(4'd7, 7'h0C, 4'd0, 3'd2, 2'b01, 4'b0101, -1, 0);
    checkOutput("t4_strb_bresp", {62'd0, bRespGot}, 64'd0);
    checkOutput("t4_reg3_strb",  {32'd0, regVal(3)}, {32'd0, 32'h11BB_33DD});
    wData[0] = 32'hFFFF_FFFF;
    axiWrite(4'd7, 7'h0C, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0);
    checkOutput("t4_par_bresp", {62'd0, bRespGot}, 64'd2);
    checkOutput("t4_reg3_par",  {32'd0, regVal(3)}, {32'd0, 32'h11BB_33DD});

    // Reset asserted while beat 1 of a 4-beat read is presented
    @(negedge clk);
    arid = 4'd3; araddr = 7'h38; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n0 = 0;
    while (!arready && n0 < 50) begin @(negedge clk); n0++; end
    checkOutput("t5_ar_handshake", {63'd0, arready}, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge clk);
    rready  = 1'b0;
    checkOutput("t5_beat1", {31'd0, rvalid, rdata}, {31'd0, 1'b1, 32'd1});
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t5_rvalid",  {63'd0, rvalid},  64'd0);
    checkOutput("t5_arready", {63'd0, arready}, 64'd0);
    checkOutput("t5_awready", {63'd0, awready}, 64'd0);
    checkOutput("t5_reg0",    {32'd0, regVal(0)},  {32'd0, ID_VALUE});
    checkOutput("t5_reg1",    {32'd0, regVal(1)},  64'd0);
    checkOutput("t5_reg3",    {32'd0, regVal(3)},  64'd0);
    checkOutput("t5_reg15",   {32'd0, regVal(15)}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("t5_rel_arready", {63'd0, arready}, 64'd1);
    axiRead(4'd8, 7'h3C, 4'd1, 3'd2, 2'b01, 0);
    checkOutput("t5_rd_reg15", {32'd0, rData[0]}, 64'd0);
    checkOutput("t5_rd_reg0",  {32'd0, rData[1]}, {32'd0, ID_VALUE});
    checkOutput("t5_rd_last",  {62'd0, rLast[0], rLast[1]}, 64'd1);
    checkOutput("t5_rd_id",    {60'd0, rId[1]}, 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
